// File: rtl/period_meter_pkg.sv
// Shared FSM encoding, control-strobe bundle and default sizing for the period meter.
package period_meter_pkg;

    localparam int unsigned CNT_W_DEF   = 28;
    localparam int unsigned TIMEOUT_DEF = 150_000_000;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ARM     = 2'd1,
        ST_MEASURE = 2'd2
    } state_e;

    typedef struct packed {
        logic start;   // first rise after arming opens a measurement
        logic report;  // closing rise of a complete period
        logic expire;  // count ran out with no rise
    } fsm_ctrl_t;

endpackage

// File: rtl/period_meter_sync_edge_det.sv
// Two-flop synchronizer for an asynchronous input plus a third flop for rise/fall detection.
module sync_edge_det (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic level,
    output logic rise,
    output logic fall
);

    logic s1_q;
    logic s2_q;
    logic s3_q;

    // NOTE: sequential state uses non-blocking assignments so every flop samples the pre-edge value.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_q <= 1'b0;
            s2_q <= 1'b0;
            s3_q <= 1'b0;
        end else begin
            s1_q <= d;
            s2_q <= s1_q;
            s3_q <= s2_q;
        end
    end

    assign level = s2_q;
    assign rise  = s2_q & ~s3_q;
    assign fall  = ~s2_q & s3_q;

endmodule

// File: rtl/period_meter.sv
// Measures period and high time of a slow asynchronous square wave in clk cycles.
module period_meter
    import period_meter_pkg::*;
#(
    parameter int unsigned CNT_W   = CNT_W_DEF,
    parameter int unsigned TIMEOUT = TIMEOUT_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             sig_in,
    output logic [CNT_W-1:0] period,
    output logic [CNT_W-1:0] high_time,
    output logic             valid,
    output logic             timeout,
    output logic             busy
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic sig_level;
    logic sig_rise;
    logic sig_fall;

    state_e    state_q;
    state_e    state_d;
    fsm_ctrl_t ctrl;
    logic      cnt_at_max;

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic [CNT_W-1:0] hcnt_q;
    logic [CNT_W-1:0] hcnt_d;
    logic [CNT_W-1:0] hold_q;
    logic [CNT_W-1:0] hold_d;

    logic [CNT_W-1:0] period_q;
    logic [CNT_W-1:0] period_d;
    logic [CNT_W-1:0] high_q;
    logic [CNT_W-1:0] high_d;
    logic             valid_q;
    logic             valid_d;
    logic             timeout_q;
    logic             timeout_d;
    logic             en_q;

    sync_edge_det u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (sig_in),
        .level (sig_level),
        .rise  (sig_rise),
        .fall  (sig_fall)
    );

    assign cnt_at_max = (cnt_q == CNT_MAX);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // NOTE: every signal written in always_comb gets a default first, so no path infers a latch.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: begin
                if (en) state_d = ST_ARM;
            end
            ST_ARM: begin
                if (!en)             state_d = ST_IDLE;
                else if (ctrl.start) state_d = ST_MEASURE;
            end
            ST_MEASURE: begin
                if (!en)              state_d = ST_IDLE;
                else if (ctrl.expire) state_d = ST_ARM;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // A rise beats an expiring count; a dropped enable suppresses both.
    always_comb begin
        ctrl = '0;
        busy = 1'b0;
        unique case (state_q)
            ST_ARM: begin
                busy       = 1'b1;
                ctrl.start = en & sig_rise;
            end
            ST_MEASURE: begin
                busy        = 1'b1;
                ctrl.report = en & sig_rise;
                ctrl.expire = en & ~sig_rise & cnt_at_max;
            end
            default: begin
                busy = 1'b0;
            end
        endcase
    end

    always_comb begin
        cnt_d  = cnt_q;
        hcnt_d = hcnt_q;
        hold_d = hold_q;
        if (state_q == ST_IDLE || ctrl.start || ctrl.report) begin
            cnt_d  = '0;
            hcnt_d = '0;
        end else if (state_q == ST_MEASURE) begin
            if (!cnt_at_max) cnt_d = cnt_q + CNT_ONE;
            if (sig_level && hcnt_q != CNT_MAX) hcnt_d = hcnt_q + CNT_ONE;
            // The opening rise cycle was high but is not in hcnt, hence the +1.
            if (sig_fall) hold_d = hcnt_q + CNT_ONE;
        end
    end

    always_comb begin
        period_d  = period_q;
        high_d    = high_q;
        valid_d   = ctrl.report;
        timeout_d = timeout_q;
        if (ctrl.report) begin
            period_d = cnt_q + CNT_ONE;
            high_d   = hold_q;
        end
        if (ctrl.expire) begin
            timeout_d = 1'b1;
        end else if (en && !en_q) begin
            timeout_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q     <= '0;
            hcnt_q    <= '0;
            hold_q    <= '0;
            period_q  <= '0;
            high_q    <= '0;
            valid_q   <= 1'b0;
            timeout_q <= 1'b0;
            en_q      <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            hcnt_q    <= hcnt_d;
            hold_q    <= hold_d;
            period_q  <= period_d;
            high_q    <= high_d;
            valid_q   <= valid_d;
            timeout_q <= timeout_d;
            en_q      <= en;
        end
    end

    assign period    = period_q;
    assign high_time = high_q;
    assign valid     = valid_q;
    assign timeout   = timeout_q;

endmodule

// File: tb/tb_period_meter.sv
// Scoreboard bench for period_meter: a cycle-index model predicts each report, a monitor checks valids.
module tb_period_meter;

    localparam int CNT_W   = 8;
    localparam int TIMEOUT = 64;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             en;
    logic             sig_in;
    logic [CNT_W-1:0] period;
    logic [CNT_W-1:0] high_time;
    logic             valid;
    logic             timeout;
    logic             busy;

    period_meter #(
        .CNT_W   (CNT_W),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .sig_in    (sig_in),
        .period    (period),
        .high_time (high_time),
        .valid     (valid),
        .timeout   (timeout),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        int period;
        int high;
    } meas_t;

    meas_t exp_q[$];
    meas_t mon_e;

    int n_checks = 0;
    int n_errors = 0;
    int cyc      = 0;

    // Reference model state, expressed in sig_in cycle indices.
    bit m_prev_s, m_prev_e, m_meas, m_fell, m_timeout;
    int m_last, m_hrun, m_last_period, m_last_high;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_prev_s      = 1'b0;
        m_prev_e      = 1'b0;
        m_meas        = 1'b0;
        m_fell        = 1'b1;
        m_timeout     = 1'b0;
        m_last        = 0;
        m_hrun        = 0;
        m_last_period = 0;
        m_last_high   = 0;
    endtask

    // Period = distance between enabled rises no more than TIMEOUT apart; high = length of the pulse.
    task automatic model_step(input bit s, input bit e);
        bit    rise;
        meas_t m;
        rise = s && !m_prev_s;
        if (!e) begin
            m_meas = 1'b0;
        end else begin
            if (!m_prev_e) m_timeout = 1'b0;
            if (rise) begin
                if (m_meas) begin
                    m.period = cyc - m_last;
                    m.high   = m_hrun;
                    exp_q.push_back(m);
                    m_last_period = m.period;
                    m_last_high   = m.high;
                end
                m_meas = 1'b1;
                m_last = cyc;
            end else if (m_meas && (cyc - m_last) >= TIMEOUT) begin
                m_timeout = 1'b1;
                m_meas    = 1'b0;
            end
        end
        if (rise) begin
            m_hrun = 0;
            m_fell = 1'b0;
        end
        if (s && !m_fell) m_hrun++;
        else if (!s)      m_fell = 1'b1;
        m_prev_s = s;
        m_prev_e = e;
    endtask

    task automatic tick(input bit s, input bit e);
        @(posedge clk);
        #1;
        sig_in = s;
        en     = e;
        cyc++;
        model_step(s, e);
    endtask

    task automatic drive_seg(input int h, input int l);
        for (int i = 0; i < h; i++) tick(1'b1, 1'b1);
        for (int i = 0; i < l; i++) tick(1'b0, 1'b1);
    endtask

    task automatic idle(input int n, input bit e);
        for (int i = 0; i < n; i++) tick(1'b0, e);
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_period"},    period,    0);
        check({tag, "_high_time"}, high_time, 0);
        check({tag, "_valid"},     valid,     0);
        check({tag, "_timeout"},   timeout,   0);
        check({tag, "_busy"},      busy,      0);
    endtask

    task automatic pulse_reset();
        @(posedge clk);
        #1;
        rst_n  = 1'b0;
        sig_in = 1'b0;
        cyc++;
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        cyc++;
        model_step(1'b0, en);
        @(negedge clk);
        check_zero("mid_reset");
    endtask

    task automatic phase_end(input string tag);
        @(negedge clk);
        check({tag, "_period"},    period,       m_last_period);
        check({tag, "_high_time"}, high_time,    m_last_high);
        check({tag, "_timeout"},   timeout,      m_timeout);
        check({tag, "_busy"},      busy,         en);
        check({tag, "_pending"},   exp_q.size(), 0);
    endtask

    // Monitor: every valid must match the oldest predicted measurement.
    always @(negedge clk) begin
        if (valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL unexpected_valid: got period=%0d high_time=%0d, expected no valid (t=%0t)",
                         period, high_time, $time);
            end else begin
                mon_e = exp_q.pop_front();
                check("valid_period",    period,    mon_e.period);
                check("valid_high_time", high_time, mon_e.high);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1);
    end

    initial begin
        rst_n  = 1'b0;
        en     = 1'b0;
        sig_in = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_zero("reset");
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // 10 high / 10 low square wave.
        idle(5, 1'b1);
        for (int i = 0; i < 6; i++) drive_seg(10, 10);
        idle(8, 1'b1);
        phase_end("sq10");

        // 3/17 duty, then sig_in stuck low until the count expires.
        for (int i = 0; i < 4; i++) drive_seg(3, 17);
        idle(80, 1'b1);
        phase_end("stuck_low");

        // Enable dropped mid-period, then raised again.
        for (int i = 0; i < 2; i++) drive_seg(10, 10);
        drive_seg(10, 5);
        tick(1'b0, 1'b0);
        tick(1'b0, 1'b0);
        @(negedge clk);
        check("en_drop_busy", busy, 0);
        idle(3, 1'b0);
        tick(1'b0, 1'b1);
        tick(1'b0, 1'b1);
        @(negedge clk);
        check("en_rise_timeout_clear", timeout, m_timeout);
        idle(5, 1'b1);
        for (int i = 0; i < 3; i++) drive_seg(10, 10);
        idle(8, 1'b1);
        phase_end("en_toggle");

        // Reset during a measurement.
        for (int i = 0; i < 2; i++) drive_seg(10, 10);
        drive_seg(10, 8);
        pulse_reset();
        idle(5, 1'b1);
        for (int i = 0; i < 3; i++) drive_seg(15, 15);
        idle(8, 1'b1);
        phase_end("after_reset");

        // Rise exactly on the last counted cycle, then one cycle too late.
        for (int i = 0; i < 3; i++) drive_seg(20, 44);
        drive_seg(20, 10);
        idle(8, 1'b1);
        phase_end("period_64");
        drive_seg(20, 45);
        drive_seg(20, 10);
        idle(8, 1'b1);
        phase_end("period_65");

        // Single-cycle pulses every 30 cycles.
        for (int i = 0; i < 5; i++) drive_seg(1, 29);
        idle(8, 1'b1);
        phase_end("pulse1");

        // Random waveform, periods straddling the timeout.
        idle(3, 1'b0);
        idle(5, 1'b1);
        for (int i = 0; i < 40; i++) begin
            drive_seg(int'($urandom_range(30, 1)), int'($urandom_range(50, 1)));
        end
        idle(80, 1'b1);
        phase_end("random");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
